// File: rtl/multiboot_pkg.sv
//------------------------------------------------------------------------------
// Module  : multiboot_pkg
// Brief   : ICAP command words, opcodes, read-mode encoding and FSM states
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package multiboot_pkg;

    localparam logic [15:0] SYNC1     = 16'hAA99;
    localparam logic [15:0] SYNC2     = 16'h5566;
    localparam logic [15:0] CMD_WR    = 16'h30A1;
    localparam logic [15:0] NULL      = 16'h0000;
    localparam logic [15:0] GEN1_WR   = 16'h3261;
    localparam logic [15:0] GEN2_WR   = 16'h3281;
    localparam logic [15:0] GEN3_WR   = 16'h32A1;
    localparam logic [15:0] GEN4_WR   = 16'h32C1;
    localparam logic [15:0] MODE_WR   = 16'h3301;
    localparam logic [15:0] IPROG     = 16'h000E;
    localparam logic [15:0] NOOP      = 16'h2000;
    localparam logic [15:0] IDLE_WORD = 16'hFFFF;

    localparam logic [7:0]  OP_X1     = 8'h03;
    localparam logic [7:0]  OP_X2     = 8'h3B;
    localparam logic [7:0]  OP_X4     = 8'h6B;
    localparam logic [15:0] MODEW_X2  = 16'h2080;
    localparam logic [15:0] MODEW_X4  = 16'h2100;

    localparam logic [1:0]  RD_X1     = 2'b00;
    localparam logic [1:0]  RD_X2     = 2'b01;
    localparam logic [1:0]  RD_X4     = 2'b10;

    typedef enum logic [4:0] {
        ST_IDLE, ST_LOAD,
        ST_SYNC1, ST_SYNC2, ST_CMD1, ST_NULL,
        ST_GEN1, ST_GEN1D, ST_GEN2, ST_GEN2D,
        ST_MODE, ST_MODED,
        ST_GEN3, ST_GEN3D, ST_GEN4, ST_GEN4D,
        ST_CMD2, ST_IPROG,
        ST_NOOP1, ST_NOOP2, ST_NOOP3, ST_NOOP4,
        ST_DONE
    } state_t;

    // ICAP on Spartan-6 expects each byte bit-reversed
    function automatic logic [15:0] byte_rev(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i]     = w[7-i];
            r[8+i]   = w[15-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/multiboot_icap_if.sv
//------------------------------------------------------------------------------
// Module  : multiboot_icap_if
// Brief   : ICAP output register with byte bit-reversal; feeds ICAP_SPARTAN6
//           (CE, WRITE, I) at chip level, clocked by the same clk_icap
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module multiboot_icap_if
    import multiboot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] word,
    input  logic        ce_n,
    output logic        icap_ce_n,
    output logic        icap_wr_n,
    output logic [15:0] icap_din
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icap_ce_n <= 1'b1;
            icap_wr_n <= 1'b1;
            icap_din  <= byte_rev(IDLE_WORD);
        end else begin
            icap_ce_n <= ce_n;
            icap_wr_n <= ce_n;
            icap_din  <= byte_rev(word);
        end
    end

endmodule

`default_nettype wire

// File: rtl/multiboot_seq.sv
//------------------------------------------------------------------------------
// Module  : multiboot_seq
// Brief   : Spartan-6 multiboot sequencer: slot/explicit address, 1x/2x/4x
//           SPI read mode, optional fallback, then IPROG through ICAP
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module multiboot_seq
    import multiboot_pkg::*;
#(
    parameter int          NUM_SLOTS       = 8,
    parameter int          SLOT_W          = 3,
    parameter logic [23:0] SLOT_BASE       = 24'h000000,
    parameter logic [23:0] SLOT_STRIDE     = 24'h0B0000,
    parameter logic [23:0] FALLBACK_ADDR   = 24'h000000,
    parameter bit          ENABLE_FALLBACK = 1'b1,
    parameter int          DEBOUNCE        = 3
)(
    input  logic              clk_icap,
    input  logic              rst_n,
    input  logic              reboot_req,
    input  logic [SLOT_W-1:0] slot_sel,
    input  logic              use_addr,
    input  logic [23:0]       addr_in,
    input  logic [1:0]        rd_mode,
    output logic              busy,
    output logic              err,
    output logic              done,
    output logic              icap_ce_n,
    output logic              icap_wr_n,
    output logic [15:0]       icap_din
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic [1:0]        r_sync;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_trigger;
    state_t            r_state;
    logic [SLOT_W-1:0] r_slot;
    logic              r_use_addr;
    logic [23:0]       r_addr_in;
    logic [23:0]       r_addr;
    logic [7:0]        r_op;
    logic              r_mode_en;
    logic [15:0]       r_modew;
    logic [15:0]       w_word;
    logic              w_ce_n;

    // Count saturates at DEBOUNCE so a held request triggers only once
    always_ff @(posedge clk_icap or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b00;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[0], reboot_req};
            if (!r_sync[1])
                r_cnt <= '0;
            else if (r_cnt != CNT_W'(DEBOUNCE))
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign w_trigger = r_sync[1] && (r_cnt == CNT_W'(DEBOUNCE - 1));

    always_ff @(posedge clk_icap or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            busy       <= 1'b0;
            err        <= 1'b0;
            done       <= 1'b0;
            r_slot     <= '0;
            r_use_addr <= 1'b0;
            r_addr_in  <= '0;
            r_addr     <= '0;
            r_op       <= OP_X1;
            r_mode_en  <= 1'b0;
            r_modew    <= MODEW_X2;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        if (!use_addr && (int'(slot_sel) >= NUM_SLOTS)) begin
                            err <= 1'b1;
                        end else begin
                            r_slot     <= slot_sel;
                            r_use_addr <= use_addr;
                            r_addr_in  <= addr_in;
                            case (rd_mode)
                                RD_X2: begin
                                    r_op <= OP_X2; r_mode_en <= 1'b1; r_modew <= MODEW_X2;
                                end
                                RD_X4: begin
                                    r_op <= OP_X4; r_mode_en <= 1'b1; r_modew <= MODEW_X4;
                                end
                                RD_X1: begin
                                    r_op <= OP_X1; r_mode_en <= 1'b0; r_modew <= MODEW_X2;
                                end
                                default: begin
                                    r_op <= OP_X1; r_mode_en <= 1'b0; r_modew <= MODEW_X2;
                                end
                            endcase
                            busy    <= 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_addr  <= r_use_addr ? r_addr_in
                                          : SLOT_BASE + 24'(r_slot) * SLOT_STRIDE;
                    r_state <= ST_SYNC1;
                end
                ST_SYNC1: r_state <= ST_SYNC2;
                ST_SYNC2: r_state <= ST_CMD1;
                ST_CMD1:  r_state <= ST_NULL;
                ST_NULL:  r_state <= ST_GEN1;
                ST_GEN1:  r_state <= ST_GEN1D;
                ST_GEN1D: r_state <= ST_GEN2;
                ST_GEN2:  r_state <= ST_GEN2D;
                ST_GEN2D: r_state <= r_mode_en ? ST_MODE
                                   : (ENABLE_FALLBACK ? ST_GEN3 : ST_CMD2);
                ST_MODE:  r_state <= ST_MODED;
                ST_MODED: r_state <= ENABLE_FALLBACK ? ST_GEN3 : ST_CMD2;
                ST_GEN3:  r_state <= ST_GEN3D;
                ST_GEN3D: r_state <= ST_GEN4;
                ST_GEN4:  r_state <= ST_GEN4D;
                ST_GEN4D: r_state <= ST_CMD2;
                ST_CMD2:  r_state <= ST_IPROG;
                ST_IPROG: r_state <= ST_NOOP1;
                ST_NOOP1: r_state <= ST_NOOP2;
                ST_NOOP2: r_state <= ST_NOOP3;
                ST_NOOP3: r_state <= ST_NOOP4;
                ST_NOOP4: r_state <= ST_DONE;
                ST_DONE: begin
                    // Last NOOP is leaving the output register this cycle
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_word = IDLE_WORD;
        w_ce_n = 1'b0;
        case (r_state)
            ST_SYNC1: w_word = SYNC1;
            ST_SYNC2: w_word = SYNC2;
            ST_CMD1:  w_word = CMD_WR;
            ST_NULL:  w_word = NULL;
            ST_GEN1:  w_word = GEN1_WR;
            ST_GEN1D: w_word = r_addr[15:0];
            ST_GEN2:  w_word = GEN2_WR;
            ST_GEN2D: w_word = {r_op, r_addr[23:16]};
            ST_MODE:  w_word = MODE_WR;
            ST_MODED: w_word = r_modew;
            ST_GEN3:  w_word = GEN3_WR;
            ST_GEN3D: w_word = FALLBACK_ADDR[15:0];
            ST_GEN4:  w_word = GEN4_WR;
            ST_GEN4D: w_word = {r_op, FALLBACK_ADDR[23:16]};
            ST_CMD2:  w_word = CMD_WR;
            ST_IPROG: w_word = IPROG;
            ST_NOOP1, ST_NOOP2, ST_NOOP3, ST_NOOP4: w_word = NOOP;
            default:  w_ce_n = 1'b1;
        endcase
    end

    multiboot_icap_if u_icap_if (
        .clk       (clk_icap),
        .rst_n     (rst_n),
        .word      (w_word),
        .ce_n      (w_ce_n),
        .icap_ce_n (icap_ce_n),
        .icap_wr_n (icap_wr_n),
        .icap_din  (icap_din)
    );

endmodule

`default_nettype wire

// File: doc/multiboot_seq.md
Name: multiboot_seq

Overview:
- Parametrised Spartan-6 ICAP multiboot sequencer. Successor to the fixed-address, 1x-only reboot engine.
- Selects one of NUM_SLOTS bitstream slots in SPI flash, or takes an explicit address.
- Programs GENERAL_1..4 with a boot address and a fallback address; optionally programs MODE_REG for 2x/4x SPI read; then issues IPROG.
- Sits between the core's reboot control (menu/keyboard logic) and the ICAP primitive.

Parameters:
- NUM_SLOTS, 8, number of selectable flash slots (2..16).
- SLOT_W, 3, width of slot_sel; must satisfy 2**SLOT_W >= NUM_SLOTS.
- SLOT_BASE, 24'h000000, flash address of slot 0.
- SLOT_STRIDE, 24'h0B0000, byte distance between consecutive slots.
- FALLBACK_ADDR, 24'h000000, golden-image address written to GENERAL_3/4.
- ENABLE_FALLBACK, 1, 1 = write GENERAL_3/4; 0 = skip those four words.
- DEBOUNCE, 3, synchronised cycles reboot_req must stay high before a trigger is accepted.

Ports:
- clk_icap  in  1  ICAP clock (≤20 MHz).
- rst_n  in  1  asynchronous, active-low reset.
- reboot_req  in  1  asynchronous request level; a trigger is a low-to-high transition held for DEBOUNCE cycles.
- slot_sel  in  SLOT_W  slot index, sampled at trigger.
- use_addr  in  1  1 = use addr_in instead of the computed slot address; sampled at trigger.
- addr_in  in  24  explicit flash address.
- rd_mode  in  2  00 = 1x, 01 = 2x, 10 = 4x, 11 = treated as 1x; sampled at trigger.
- busy  out  1  high while the sequence runs.
- err  out  1  one-cycle pulse when a request is rejected.
- done  out  1  one-cycle pulse after the last NOOP (simulation visibility only; silicon reconfigures).
- icap_ce_n  out  1  registered ICAP CE, active low.
- icap_wr_n  out  1  registered ICAP WRITE, active low.
- icap_din  out  16  registered, bit-swapped ICAP data.

Behaviour:
- Reset values: busy=0, err=0, done=0, icap_ce_n=1, icap_wr_n=1, icap_din=swap(16'hFFFF). State=IDLE; synchroniser and debounce counter cleared.
- Input capture: 2-FF synchroniser on reboot_req. The debounce counter counts consecutive high cycles and clears on any low. A trigger fires on the cycle the count reaches DEBOUNCE, once per high period.
- Trigger while busy: ignored, no err.
- Trigger with use_addr=0 and slot_sel >= NUM_SLOTS: err pulses the next cycle and the FSM stays IDLE.
- Address computation: addr = use_addr ? addr_in : SLOT_BASE + slot_sel*SLOT_STRIDE, truncated to 24 bits (wraps). Latched with the opcode at trigger.
- Opcode: 03 for 1x, 3B for 2x, 6B for 4x.
- FSM: IDLE -> LOAD -> one state per word -> DONE -> IDLE. LOAD asserts busy and computes the address.
- Word stream, one per clock with ce/wr low:
  - AA99, 5566, 30A1, 0000
  - 3261, addr[15:0]
  - 3281, {op, addr[23:16]}
  - [3301, MODEW] only when rd_mode is 2x/4x
  - [32A1, FALLBACK_ADDR[15:0], 32C1, {op, FALLBACK_ADDR[23:16]}] only when ENABLE_FALLBACK=1
  - 30A1, 000E, 2000 x4
- MODEW: 16'h2100 for 4x, 16'h2080 for 2x.
- Word count: 14 base, +2 for MODE, +4 for fallback (14..20).
- Latency: first word (AA99) appears on icap_din 2 cycles after trigger (LOAD plus output register). Words are contiguous with no gaps.
- After the last NOOP: ce_n/wr_n return to 1, din = swap(FFFF), done pulses once, and busy drops in the same cycle.
- Bit swap: each byte is bit-reversed in place (din[7:0] = rev(w[7:0]), din[15:8] = rev(w[15:8])).
- Reset mid-sequence: outputs return immediately (asynchronously) to reset values; no partial-sequence resume.

Decomposition:
- Package multiboot_pkg:
  - ICAP command constants: SYNC1, SYNC2, CMD_WR, NULL, GEN1..4_WR, MODE_WR, IPROG, NOOP, IDLE_WORD.
  - Opcodes OP_X1/X2/X4, MODE words MODEW_X2/X4.
  - rd_mode encoding, FSM state enum.
- Sub-module multiboot_icap_if: output register plus byte bit-reversal, driving ICAP_SPARTAN6 (CE, WRITE, I, CLK). The FSM stays free of primitives.

Test Plan:
- Default params, slot_sel=1, rd_mode=00 -> 18 words: AA99, 5566, 30A1, 0000, 3261, 0000, 3281, 030B, 32A1, 0000, 32C1, 0300, 30A1, 000E, 2000x4. busy high for the whole sequence; done pulses once.
- use_addr=1, addr_in=24'h123456, rd_mode=10 -> GEN words 3456 and 6B12, plus 3301/2100 after GEN2. Total 20 words.
- slot_sel=7 with SLOT_STRIDE=24'h400000 -> address wraps to 24'hC00000 (28'h1C00000 truncated), giving GEN2 word 03C0. With NUM_SLOTS=6 and slot_sel=6 -> err pulse, icap_ce_n stays 1.
- reboot_req high for only DEBOUNCE-1 cycles -> no trigger. A second trigger during busy -> ignored; stream unchanged.
- rst_n low at word 8 -> icap_ce_n=1 and busy=0 immediately. A new trigger after release -> full sequence from AA99.
- ENABLE_FALLBACK=0, rd_mode=01 -> 16 words, MODE 2080, opcode 3B in the GEN2 high byte. A checker verifies the icap_din byte bit-reversal on every word.
